// File: rtl/niosii_debug_scan_master.sv
// niosii_debug_scan_master: runs one virtual-JTAG scan (UIR, CDR, DR_WIDTH x SDR, UDR) per command
module niosii_debug_scan_master #(
    parameter int DR_WIDTH = 38,
    parameter int IR_WIDTH = 2,
    parameter int TCK_DIV  = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [IR_WIDTH-1:0] cmd_ir,
    input  logic [DR_WIDTH-1:0] cmd_dr,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DR_WIDTH-1:0] rsp_dr,
    output logic [IR_WIDTH-1:0] rsp_ir_out,
    output logic                busy,
    output logic                tck,
    output logic                tdi,
    input  logic                tdo,
    output logic [IR_WIDTH-1:0] ir_in,
    input  logic [IR_WIDTH-1:0] ir_out,
    output logic                vs_uir,
    output logic                vs_cdr,
    output logic                vs_sdr,
    output logic                vs_udr,
    output logic                jtag_state_rti
);
    localparam int DW = $clog2(2 * TCK_DIV);
    localparam int BW = $clog2(DR_WIDTH + 1);
    typedef enum logic [2:0] {IDLE, UIR, CDR, SDR, UDR, RESP} state_t;
    state_t state;
    logic [DW-1:0] div;
    logic [BW-1:0] bit_cnt;
    logic [DR_WIDTH-1:0] shreg;
    logic active, rise, period_end;
    assign active = state != IDLE && state != RESP;
    assign rise = active && div == DW'(TCK_DIV - 1);
    assign period_end = active && div == DW'(2 * TCK_DIV - 1);
    assign cmd_ready = state == IDLE && !rsp_valid;
    assign busy = state != IDLE;
    assign jtag_state_rti = state == IDLE;
    assign vs_uir = state == UIR;
    assign vs_cdr = state == CDR;
    assign vs_sdr = state == SDR;
    assign vs_udr = state == UDR;
    assign tdi = vs_sdr & shreg[0];
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            div        <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            tck        <= 1'b0;
            ir_in      <= '0;
            rsp_valid  <= 1'b0;
            rsp_dr     <= '0;
            rsp_ir_out <= '0;
        end else if (state == IDLE) begin
            if (cmd_valid && cmd_ready) begin
                shreg   <= cmd_dr;
                ir_in   <= cmd_ir;
                state   <= UIR;
                div     <= '0;
                bit_cnt <= '0;
                tck     <= 1'b0;
            end
        end else if (state == RESP) begin
            if (rsp_ready) begin
                rsp_valid <= 1'b0;
                ir_in     <= '0;
                state     <= IDLE;
            end
        end else begin
            div <= period_end ? '0 : div + 1'b1;
            tck <= !period_end && (rise || tck);
            // tdo is captured on the tck rising transition, mid-period
            if (rise && state == SDR) shreg <= {tdo, shreg[DR_WIDTH-1:1]};
            if (rise && state == CDR) rsp_ir_out <= ir_out;
            if (period_end) begin
                case (state)
                    UIR: state <= CDR;
                    CDR: state <= SDR;
                    SDR: begin
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == BW'(DR_WIDTH - 1)) state <= UDR;
                    end
                    UDR: begin
                        state     <= RESP;
                        rsp_dr    <= shreg;
                        rsp_valid <= 1'b1;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_niosii_debug_scan_master.sv
// tb_niosii_debug_scan_master: random scans against a loopback target model and a TCK_DIV=1 self-loop instance
module tb_niosii_debug_scan_master;
    localparam int DRW = 38;
    logic clk = 0, reset_n = 0;
    logic cmd_valid = 0, rsp_ready = 0, tdo;
    logic [1:0] cmd_ir = 0, ir_out = 0, ir_in, rsp_ir_out, exp_ir = 0;
    logic [DRW-1:0] cmd_dr = 0, rsp_dr, cdr_val = 0, tsr = 0;
    logic cmd_ready, rsp_valid, busy, tck, tdi, vs_uir, vs_cdr, vs_sdr, vs_udr, rti;
    logic cmd_valid1 = 0, rsp_ready1 = 0;
    logic [DRW-1:0] cmd_dr1 = 0, rsp_dr1;
    logic [1:0] ir_in1, rsp_ir_out1;
    logic cmd_ready1, rsp_valid1, busy1, tck1, tdi1, vs1_uir, vs1_cdr, vs1_sdr, vs1_udr, rti1;
    logic tdi_q = 0, tck_q = 0;
    int n_uir = 0, n_cdr = 0, n_sdr = 0, n_udr = 0, n_rise = 0, ir_bad = 0, n_tck1 = 0, n_vs1 = 0;
    int vecs = 0, errs = 0;

    niosii_debug_scan_master u_dut (
        .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_ir(cmd_ir), .cmd_dr(cmd_dr), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_dr(rsp_dr), .rsp_ir_out(rsp_ir_out), .busy(busy), .tck(tck), .tdi(tdi),
        .tdo(tdo), .ir_in(ir_in), .ir_out(ir_out), .vs_uir(vs_uir), .vs_cdr(vs_cdr),
        .vs_sdr(vs_sdr), .vs_udr(vs_udr), .jtag_state_rti(rti)
    );

    niosii_debug_scan_master #(.TCK_DIV(1)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1),
        .cmd_ir(2'd3), .cmd_dr(cmd_dr1), .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1),
        .rsp_dr(rsp_dr1), .rsp_ir_out(rsp_ir_out1), .busy(busy1), .tck(tck1), .tdi(tdi1),
        .tdo(tdi1), .ir_in(ir_in1), .ir_out(2'd1), .vs_uir(vs1_uir), .vs_cdr(vs1_cdr),
        .vs_sdr(vs1_sdr), .vs_udr(vs1_udr), .jtag_state_rti(rti1)
    );

    always #5 clk = ~clk;

    // Target debug slave: captures cdr_val in CDR, shifts tdi into its MSB on each SDR tck rise
    assign tdo = tsr[0];
    always @(posedge tck)
        if (vs_cdr) tsr <= cdr_val;
        else if (vs_sdr) tsr <= {tdi_q, tsr[DRW-1:1]};

    always @(negedge clk) begin
        tdi_q  <= tdi;
        tck_q  <= tck;
        n_uir  <= n_uir + int'(vs_uir);
        n_cdr  <= n_cdr + int'(vs_cdr);
        n_sdr  <= n_sdr + int'(vs_sdr);
        n_udr  <= n_udr + int'(vs_udr);
        n_rise <= n_rise + int'(vs_sdr && tck && !tck_q);
        ir_bad <= ir_bad + int'(busy && ir_in !== exp_ir);
        n_tck1 <= n_tck1 + int'(tck1);
        n_vs1  <= n_vs1 + int'(vs1_uir) + int'(vs1_cdr) + int'(vs1_sdr) + int'(vs1_udr);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle_checks();
        chk("tck", tck, 0); chk("tdi", tdi, 0); chk("ir_in", ir_in, 0);
        chk("vs", {vs_uir, vs_cdr, vs_sdr, vs_udr}, 0); chk("rti", rti, 1);
        chk("busy", busy, 0); chk("rsp_valid", rsp_valid, 0);
    endtask

    task automatic scan0(input logic [1:0] ir, input logic [DRW-1:0] dr, cv, input logic [1:0] io, input int hold);
        int n, b_uir, b_cdr, b_sdr, b_udr, b_rise, b_bad;
        cdr_val = cv; ir_out = io; exp_ir = ir;
        @(negedge clk);
        chk("cmd_ready", cmd_ready, 1);
        b_uir = n_uir; b_cdr = n_cdr; b_sdr = n_sdr; b_udr = n_udr; b_rise = n_rise; b_bad = ir_bad;
        cmd_ir = ir; cmd_dr = dr; cmd_valid = 1;
        @(posedge clk); #1;
        cmd_valid = 0; n = 0;
        while (!rsp_valid && n < 400) begin
            if (n == 60) begin cmd_valid = 1; cmd_dr = ~dr; cmd_ir = ~ir; end
            if (n == 62) cmd_valid = 0;
            @(posedge clk); #1; n++;
        end
        chk("latency", n, 164);
        chk("rsp_dr", rsp_dr, cv);
        chk("rsp_ir_out", rsp_ir_out, io);
        chk("target_sr", tsr, dr);
        chk("uir_cycles", n_uir - b_uir, 4);
        chk("cdr_cycles", n_cdr - b_cdr, 4);
        chk("sdr_cycles", n_sdr - b_sdr, 152);
        chk("udr_cycles", n_udr - b_udr, 4);
        chk("sdr_rises", n_rise - b_rise, 38);
        for (int i = 0; i < hold; i++) begin
            cmd_valid = (i == hold / 2);
            @(negedge clk);
            chk("hold_valid", rsp_valid, 1); chk("hold_dr", rsp_dr, cv); chk("hold_ready", cmd_ready, 0);
        end
        cmd_valid = 0;
        chk("ir_in_scan", ir_bad - b_bad, 0);
        chk("ir_in_resp", ir_in, ir);
        rsp_ready = 1;
        @(posedge clk); #1;
        rsp_ready = 0;
        chk("rsp_drop", rsp_valid, 0); chk("ir_clr", ir_in, 0); chk("busy_clr", busy, 0);
    endtask

    task automatic scan1(input logic [DRW-1:0] dr);
        int n, b_tck, b_vs;
        @(negedge clk);
        chk("cmd_ready1", cmd_ready1, 1);
        b_tck = n_tck1; b_vs = n_vs1;
        cmd_dr1 = dr; cmd_valid1 = 1;
        @(posedge clk); #1;
        cmd_valid1 = 0; n = 0;
        while (!rsp_valid1 && n < 400) begin @(posedge clk); #1; n++; end
        chk("latency1", n, 82);
        chk("rsp_dr1", rsp_dr1, dr);
        chk("rsp_ir_out1", rsp_ir_out1, 1);
        chk("tck1_high", n_tck1 - b_tck, 41);
        chk("vs1_cycles", n_vs1 - b_vs, 82);
        rsp_ready1 = 1;
        @(posedge clk); #1;
        rsp_ready1 = 0;
        chk("rsp_drop1", rsp_valid1, 0); chk("busy1", busy1, 0); chk("rti1", rti1, 1); chk("ir_clr1", ir_in1, 0);
    endtask

    initial begin
        int n, b_rise, seen;
        logic [DRW-1:0] dr, cv;
        repeat (3) @(negedge clk);
        idle_checks();
        chk("rst_rsp_dr", rsp_dr, 0); chk("rst_ir_out", rsp_ir_out, 0);
        reset_n = 1;
        @(negedge clk);
        idle_checks();
        chk("cmd_ready_rst", cmd_ready, 1);
        scan0(2'd2, 38'h15_1234_5678, 38'h2A_5A5A_5A5A, 2'd0, 20);
        scan0(2'd1, 38'h0, 38'h3F_FFFF_FFFF, 2'd3, 0);
        for (int k = 0; k < 4; k++) begin
            dr = 38'({$urandom(), $urandom()});
            cv = 38'({$urandom(), $urandom()});
            scan0(2'($urandom()), dr, cv, 2'($urandom()), int'($urandom_range(0, 20)));
        end
        // Abort mid-SDR with reset
        cdr_val = 38'h0A_AAAA_AAAA; exp_ir = 2'd3;
        @(negedge clk);
        b_rise = n_rise;
        cmd_ir = 2'd3; cmd_dr = 38'h12_3456_789A; cmd_valid = 1;
        @(posedge clk); #1;
        cmd_valid = 0; n = 0;
        while (n_rise - b_rise < 10 && n < 400) begin @(posedge clk); #1; n++; end
        chk("sdr_reached", n_rise - b_rise, 10);
        reset_n = 0;
        @(negedge clk);
        idle_checks();
        reset_n = 1;
        seen = 0;
        repeat (200) begin @(negedge clk); seen += int'(rsp_valid) + int'(busy); end
        chk("abort_no_rsp", seen, 0);
        scan0(2'd2, 38'h15_1234_5678, 38'h2A_5A5A_5A5A, 2'd1, 3);
        scan1({DRW{1'b1}});
        scan1({DRW{1'b0}});
        scan1(38'({$urandom(), $urandom()}));
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
